// File: rtl/cycle_sequencer.sv
// cycle_sequencer
// Per-instruction timing sequencer for the 6502 core. It latches the opcode
// in the fetch (sync) cycle, derives the instruction length from the
// addressing-mode bits and counts T-states upward. It can stretch an
// instruction by one cycle on an indexed page cross, and it freezes all state
// while rdy is low. It also sequences reset entry and interrupt entry.
//
// Ports:
//   clk          system clock, rising edge
//   res          synchronous active-high reset
//   rdy          1 = advance, 0 = hold all sequencer state
//   instruction  opcode byte on the bus, sampled in the sync cycle
//   i_flag       status I bit, masks irq when set
//   irq          level-sensitive interrupt request
//   nmi          edge-sensitive interrupt request (rising edge latched)
//   page_cross   indexed address crossed a page
//   sync         opcode fetch cycle of a normal instruction
//   opcode       latched opcode, 8'h00 during reset/interrupt sequences
//   t_state      cycle index within the current sequence
//   last_cycle   final cycle of the current sequence
//   mode         00 normal, 01 reset, 10 nmi, 11 irq
//   nmi_ack      first cycle of an NMI entry sequence
module cycle_sequencer #(
  parameter int T_W          = 3,
  parameter int RESET_CYCLES = 7,
  parameter int INT_CYCLES   = 7
) (
  input  logic           clk,
  input  logic           res,
  input  logic           rdy,
  input  logic [7:0]     instruction,
  input  logic           i_flag,
  input  logic           irq,
  input  logic           nmi,
  input  logic           page_cross,
  output logic           sync,
  output logic [7:0]     opcode,
  output logic [T_W-1:0] t_state,
  output logic           last_cycle,
  output logic [1:0]     mode,
  output logic           nmi_ack
);

  localparam logic [1:0] MODE_NORMAL = 2'b00;
  localparam logic [1:0] MODE_RESET  = 2'b01;
  localparam logic [1:0] MODE_NMI    = 2'b10;
  localparam logic [1:0] MODE_IRQ    = 2'b11;

  // len holds values up to 2^T_W, so it needs one more bit than t_state
  localparam int              LW        = T_W + 1;
  localparam logic [LW-1:0]   RESET_LEN = LW'(RESET_CYCLES);
  localparam logic [LW-1:0]   INT_LEN   = LW'(INT_CYCLES);

  logic [1:0]     mode_q, mode_d;
  logic [T_W-1:0] t_q, t_d;
  logic [7:0]     opcode_q, opcode_d;
  logic [LW-1:0]  len_q, len_d;
  logic           pc_done_q, pc_done_d;
  logic           nmi_prev_q;
  logic           nmi_pending_q, nmi_pending_d;

  logic sync_w;
  logic last_w;
  logic pc_ok;

  // Instruction length from the opcode bits aaabbbcc
  function automatic logic [3:0] op_len(input logic [7:0] op);
    logic [3:0] len;
    case (op[4:2])
      3'b000:  len = 4'd6;
      3'b001:  len = 4'd3;
      3'b010:  len = 4'd2;
      3'b011:  len = 4'd4;
      3'b100:  len = 4'd5;
      default: len = 4'd4;
    endcase
    if (op == 8'h00) begin
      len = 4'd7;
    end else if (op[3:0] == 4'h8 || op[3:0] == 4'hA) begin
      len = 4'd2;
    end else if (op[1:0] == 2'b10 && op[7:5] != 3'b100 &&
                 op[7:5] != 3'b101 && op[2]) begin
      // read-modify-write forms take a read and a dummy write
      len = len + 4'd2;
    end
    return len;
  endfunction

  assign sync_w = (mode_q == MODE_NORMAL) && (t_q == '0);
  // sync cycle can never be last since the shortest instruction is 2 cycles
  assign last_w = !sync_w && ({1'b0, t_q} == len_q - LW'(1));

  // Only indexed-read forms of the cc=01 group pay the page-cross cycle,
  // and only once per instruction
  assign pc_ok = (mode_q == MODE_NORMAL) && (opcode_q[1:0] == 2'b01) &&
                 (opcode_q[4:2] == 3'b100 || opcode_q[4:2] == 3'b110 ||
                  opcode_q[4:2] == 3'b111) && !pc_done_q;

  always_comb begin
    mode_d        = mode_q;
    t_d           = t_q;
    opcode_d      = opcode_q;
    len_d         = len_q;
    pc_done_d     = pc_done_q;
    nmi_pending_d = nmi_pending_q;

    if (rdy) begin
      if (sync_w) begin
        opcode_d  = instruction;
        len_d     = LW'(op_len(instruction));
        t_d       = t_q + T_W'(1);
        pc_done_d = 1'b0;
      end else if (last_w) begin
        // interrupts are only ever taken at a sequence boundary
        t_d = '0;
        if (nmi_pending_q) begin
          mode_d        = MODE_NMI;
          len_d         = INT_LEN;
          opcode_d      = 8'h00;
          nmi_pending_d = 1'b0;
        end else if (irq && !i_flag) begin
          mode_d   = MODE_IRQ;
          len_d    = INT_LEN;
          opcode_d = 8'h00;
        end else begin
          mode_d = MODE_NORMAL;
        end
      end else begin
        t_d = t_q + T_W'(1);
        if (page_cross && pc_ok) begin
          len_d     = len_q + LW'(1);
          pc_done_d = 1'b1;
        end
      end
    end

    // a fresh edge wins over a same-cycle clear
    if (nmi && !nmi_prev_q) begin
      nmi_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      mode_q        <= MODE_RESET;
      t_q           <= '0;
      opcode_q      <= 8'h00;
      len_q         <= RESET_LEN;
      pc_done_q     <= 1'b0;
      nmi_prev_q    <= 1'b0;
      nmi_pending_q <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      t_q           <= t_d;
      opcode_q      <= opcode_d;
      len_q         <= len_d;
      pc_done_q     <= pc_done_d;
      nmi_prev_q    <= nmi;
      nmi_pending_q <= nmi_pending_d;
    end
  end

  assign sync       = sync_w;
  assign last_cycle = last_w;
  assign opcode     = opcode_q;
  assign t_state    = t_q;
  assign mode       = mode_q;
  assign nmi_ack    = (mode_q == MODE_NMI) && (t_q == '0);

endmodule

// File: tb/tb_cycle_sequencer.sv
// tb_cycle_sequencer
// Scoreboard bench for cycle_sequencer. Each scenario task plans a run as a
// list of cycle steps. Each step holds the inputs to apply for that cycle and
// the outputs the sequencer must show during it. The task then replays the
// queue and compares every step.
module tb_cycle_sequencer;

  logic       clk;
  logic       res;
  logic       rdy;
  logic [7:0] instruction;
  logic       i_flag;
  logic       irq;
  logic       nmi;
  logic       page_cross;
  logic       sync;
  logic [7:0] opcode;
  logic [2:0] t_state;
  logic       last_cycle;
  logic [1:0] mode;
  logic       nmi_ack;

  typedef struct packed {
    logic       res;
    logic       rdy;
    logic       pc;
    logic       nmi;
    logic       irq;
    logic       iflag;
    logic [7:0] instr;
  } stim_t;

  typedef struct packed {
    logic [1:0] mode;
    logic [2:0] t;
    logic       sync;
    logic       last;
    logic       ack;
    logic [7:0] op;
  } exp_t;

  typedef struct packed {
    stim_t s;
    exp_t  e;
  } step_t;

  step_t      sbq[$];
  int         numChecks = 0;
  int         numErrors = 0;
  logic [7:0] curOp;
  logic       nmiLvl;
  logic       irqLvl;
  logic       iflagLvl;

  cycle_sequencer #(
    .T_W(3),
    .RESET_CYCLES(7),
    .INT_CYCLES(7)
  ) dut (
    .clk(clk),
    .res(res),
    .rdy(rdy),
    .instruction(instruction),
    .i_flag(i_flag),
    .irq(irq),
    .nmi(nmi),
    .page_cross(page_cross),
    .sync(sync),
    .opcode(opcode),
    .t_state(t_state),
    .last_cycle(last_cycle),
    .mode(mode),
    .nmi_ack(nmi_ack)
  );

  // free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // hard stop in case a scenario ever stops advancing
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", numErrors);
    $fatal(1, "[TB] watchdog expired");
  end

  // drive one cycle's worth of inputs
  task automatic applyStimulus(input stim_t s);
    res         = s.res;
    rdy         = s.rdy;
    page_cross  = s.pc;
    nmi         = s.nmi;
    irq         = s.irq;
    i_flag      = s.iflag;
    instruction = s.instr;
  endtask

  // plan one reset-sequence cycle
  task automatic addReset(input int t, input logic resBit);
    step_t s;
    s.s = '{res: resBit, rdy: 1'b1, pc: 1'b0, nmi: 1'b0, irq: 1'b0, iflag: 1'b0, instr: 8'h00};
    s.e.mode = 2'b01;
    s.e.t    = 3'(t);
    s.e.sync = 1'b0;
    s.e.last = (t == 6);
    s.e.ack  = 1'b0;
    s.e.op   = 8'h00;
    sbq.push_back(s);
  endtask

  // plan one normal instruction of known length; pcMask selects the
  // t_states with page_cross high, stallAt/stallN insert rdy=0 cycles,
  // intAt raises nmi and irq (with I clear) in that t_state
  task automatic addInstr(input logic [7:0] op, input int len, input int pcMask,
                          input int stallAt, input int stallN, input int intAt);
    step_t s;
    for (int t = 0; t < len; t++) begin
      if (t == intAt) begin
        nmiLvl   = 1'b1;
        irqLvl   = 1'b1;
        iflagLvl = 1'b0;
      end
      s.e.mode  = 2'b00;
      s.e.t     = 3'(t);
      s.e.sync  = (t == 0);
      s.e.last  = (t == len - 1);
      s.e.ack   = 1'b0;
      s.e.op    = (t == 0) ? curOp : op;
      s.s.res   = 1'b0;
      s.s.pc    = 1'b0;
      s.s.nmi   = nmiLvl;
      s.s.irq   = irqLvl;
      s.s.iflag = iflagLvl;
      s.s.instr = op;
      if (t == stallAt) begin
        for (int k = 0; k < stallN; k++) begin
          s.s.rdy = 1'b0;
          sbq.push_back(s);
        end
      end
      s.s.rdy = 1'b1;
      s.s.pc  = pcMask[t];
      sbq.push_back(s);
    end
    curOp = op;
  endtask

  // plan an interrupt entry sequence
  task automatic addSeq(input logic [1:0] m, input int len, input logic ack);
    step_t s;
    for (int t = 0; t < len; t++) begin
      s.s = '{res: 1'b0, rdy: 1'b1, pc: 1'b0, nmi: nmiLvl, irq: irqLvl, iflag: iflagLvl, instr: 8'h00};
      s.e.mode = m;
      s.e.t    = 3'(t);
      s.e.sync = 1'b0;
      s.e.last = (t == len - 1);
      s.e.ack  = ack && (t == 0);
      s.e.op   = 8'h00;
      sbq.push_back(s);
    end
    curOp = 8'h00;
  endtask

  // reset held, reset sequence, and a reset restart mid-sequence
  task automatic test_reset();
    step_t cur;
    int    stepIdx = 0;
    addReset(0, 1'b1);
    addReset(0, 1'b1);
    for (int t = 0; t <= 3; t++) addReset(t, (t == 3));
    for (int t = 0; t <= 6; t++) addReset(t, 1'b0);
    while (sbq.size() != 0) begin
      cur = sbq.pop_front();
      numChecks++;
      if ({mode, t_state, sync, last_cycle, nmi_ack, opcode} !== cur.e) begin
        numErrors++;
        $display("[TB] FAIL reset step %0d: got %h expected %h (mode,t,sync,last,ack,op packed)",
                 stepIdx, {mode, t_state, sync, last_cycle, nmi_ack, opcode}, cur.e);
      end
      applyStimulus(cur.s);
      @(posedge clk); #1;
      stepIdx++;
    end
  endtask

  // lengths for immediate, absolute, read-modify-write and implied forms
  task automatic test_lengths();
    step_t cur;
    int    stepIdx = 0;
    addInstr(8'hA9, 2, 0, -1, 0, -1);
    addInstr(8'hAD, 4, 0, -1, 0, -1);
    addInstr(8'h06, 5, 0, -1, 0, -1);
    addInstr(8'hEA, 2, 0, -1, 0, -1);
    addInstr(8'h00, 7, 0, -1, 0, -1);
    addInstr(8'h0E, 6, 0, -1, 0, -1);
    while (sbq.size() != 0) begin
      cur = sbq.pop_front();
      numChecks++;
      if ({mode, t_state, sync, last_cycle, nmi_ack, opcode} !== cur.e) begin
        numErrors++;
        $display("[TB] FAIL lengths step %0d: got %h expected %h (mode,t,sync,last,ack,op packed)",
                 stepIdx, {mode, t_state, sync, last_cycle, nmi_ack, opcode}, cur.e);
      end
      applyStimulus(cur.s);
      @(posedge clk); #1;
      stepIdx++;
    end
  endtask

  // page-cross extension, once only, ignored on sync/last and other opcodes
  task automatic test_page_cross();
    step_t cur;
    int    stepIdx = 0;
    addInstr(8'hBD, 5, 32'h4,  -1, 0, -1);
    addInstr(8'hBD, 4, 0,      -1, 0, -1);
    addInstr(8'h06, 5, 32'h4,  -1, 0, -1);
    addInstr(8'hBD, 5, 32'hFF, -1, 0, -1);
    addInstr(8'hBD, 4, 32'h8,  -1, 0, -1);
    addInstr(8'hAD, 4, 32'h4,  -1, 0, -1);
    while (sbq.size() != 0) begin
      cur = sbq.pop_front();
      numChecks++;
      if ({mode, t_state, sync, last_cycle, nmi_ack, opcode} !== cur.e) begin
        numErrors++;
        $display("[TB] FAIL page_cross step %0d: got %h expected %h (mode,t,sync,last,ack,op packed)",
                 stepIdx, {mode, t_state, sync, last_cycle, nmi_ack, opcode}, cur.e);
      end
      applyStimulus(cur.s);
      @(posedge clk); #1;
      stepIdx++;
    end
  endtask

  // rdy low mid-instruction and in the sync cycle
  task automatic test_stall();
    step_t cur;
    int    stepIdx = 0;
    addInstr(8'hAD, 4, 0, 2, 3, -1);
    addInstr(8'hA9, 2, 0, 0, 2, -1);
    while (sbq.size() != 0) begin
      cur = sbq.pop_front();
      numChecks++;
      if ({mode, t_state, sync, last_cycle, nmi_ack, opcode} !== cur.e) begin
        numErrors++;
        $display("[TB] FAIL stall step %0d: got %h expected %h (mode,t,sync,last,ack,op packed)",
                 stepIdx, {mode, t_state, sync, last_cycle, nmi_ack, opcode}, cur.e);
      end
      applyStimulus(cur.s);
      @(posedge clk); #1;
      stepIdx++;
    end
  endtask

  // NMI edge and IRQ raised together mid-instruction: NMI first, then IRQ
  task automatic test_interrupts();
    step_t cur;
    int    stepIdx = 0;
    addInstr(8'hAD, 4, 0, -1, 0, 1);
    addSeq(2'b10, 7, 1'b1);
    irqLvl = 1'b0;
    nmiLvl = 1'b0;
    addSeq(2'b11, 7, 1'b0);
    addInstr(8'hEA, 2, 0, -1, 0, -1);
    while (sbq.size() != 0) begin
      cur = sbq.pop_front();
      numChecks++;
      if ({mode, t_state, sync, last_cycle, nmi_ack, opcode} !== cur.e) begin
        numErrors++;
        $display("[TB] FAIL interrupts step %0d: got %h expected %h (mode,t,sync,last,ack,op packed)",
                 stepIdx, {mode, t_state, sync, last_cycle, nmi_ack, opcode}, cur.e);
      end
      applyStimulus(cur.s);
      @(posedge clk); #1;
      stepIdx++;
    end
  endtask

  // IRQ masked by I, then taken at the boundary after I clears
  task automatic test_irq_mask();
    step_t cur;
    int    stepIdx = 0;
    iflagLvl = 1'b1;
    irqLvl   = 1'b1;
    addInstr(8'hEA, 2, 0, -1, 0, -1);
    addInstr(8'hA9, 2, 0, -1, 0, -1);
    iflagLvl = 1'b0;
    addInstr(8'hAD, 4, 0, -1, 0, -1);
    irqLvl = 1'b0;
    addSeq(2'b11, 7, 1'b0);
    addInstr(8'hEA, 2, 0, -1, 0, -1);
    while (sbq.size() != 0) begin
      cur = sbq.pop_front();
      numChecks++;
      if ({mode, t_state, sync, last_cycle, nmi_ack, opcode} !== cur.e) begin
        numErrors++;
        $display("[TB] FAIL irq_mask step %0d: got %h expected %h (mode,t,sync,last,ack,op packed)",
                 stepIdx, {mode, t_state, sync, last_cycle, nmi_ack, opcode}, cur.e);
      end
      applyStimulus(cur.s);
      @(posedge clk); #1;
      stepIdx++;
    end
  endtask

  // run all scenarios back to back; each ends in a sync cycle
  initial begin
    curOp    = 8'h00;
    nmiLvl   = 1'b0;
    irqLvl   = 1'b0;
    iflagLvl = 1'b0;
    applyStimulus('{res: 1'b1, rdy: 1'b1, pc: 1'b0, nmi: 1'b0, irq: 1'b0, iflag: 1'b0, instr: 8'h00});
    @(posedge clk); #1;
    test_reset();
    test_lengths();
    test_page_cross();
    test_stall();
    test_interrupts();
    test_irq_mask();
    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule

// File: doc/cycle_sequencer.md
Name: cycle_sequencer

Overview:
Parametrised per-instruction timing sequencer for the 6502 core and successor to the countdown logic in instruction decode.
- Latches the opcode in the fetch (sync) cycle and derives the cycle length from the opcode's addressing-mode bits.
- Counts T-states upward, with optional page-cross extension and a full stall on rdy.
- Sequences reset and interrupt entry (NMI edge, IRQ level masked by the I flag).
- Feeds t_state, opcode and mode to the downstream control decode that drives the register and ALU enables.

Parameters:
T_W, 3, width of t_state; maximum sequence length is 2^T_W.
RESET_CYCLES, 7, length of the reset sequence after res deasserts (2..2^T_W).
INT_CYCLES, 7, length of the NMI/IRQ entry sequence (2..2^T_W).

Ports:
clk  in  1  system clock; all state updates on the rising edge.
res  in  1  synchronous, active-high reset.
rdy  in  1  1 = advance; 0 = freeze all sequencer state this cycle.
instruction  in  8  opcode byte on the bus; sampled in the sync cycle.
i_flag  in  1  processor status I bit; 1 masks irq.
irq  in  1  level-sensitive interrupt request, active-high.
nmi  in  1  edge-sensitive interrupt request; a rising edge latches it.
page_cross  in  1  indexed address crossed a page; extends the current instruction.
sync  out  1  1 in the opcode fetch cycle of a normal instruction.
opcode  out  8  latched opcode; forced to 8'h00 during reset/NMI/IRQ sequences.
t_state  out  T_W  cycle index within the current sequence; 0 = first cycle.
last_cycle  out  1  1 when t_state == len-1.
mode  out  2  00 normal, 01 reset, 10 nmi, 11 irq.
nmi_ack  out  1  one-cycle pulse on the first cycle of an NMI sequence.

Behaviour:
- Reset: while res=1 → mode=01, t_state=0, opcode=00, sync=0, last_cycle=0, nmi_ack=0, nmi_pending=0, nmi edge register=0.
  - After res falls, the reset sequence runs RESET_CYCLES cycles (t_state 0..RESET_CYCLES-1).
  - The next cycle is sync with mode=00.
  - res asserted mid-sequence restarts the reset sequence from t_state=0.
- Stall: rdy=0 → t_state, opcode, len, mode and the page-cross flag hold; outputs are stable; nmi edge detection still runs.
- Sync cycle (mode=00, t_state=0): sync=1; last_cycle=0 (minimum length is 2). On the clock edge with rdy=1, opcode<=instruction and len<=f(instruction).
- Length f(op), with op=aaabbbcc:
  - Base length from bbb: 000:6, 001:3, 010:2, 011:4, 100:5, 101:4, 110:4, 111:4.
  - Override 8'h00 (BRK) = 7.
  - Override low nibble 8 or A (implied/accumulator) = 2.
  - cc=10 with aaa ∉ {100,101} and bbb ∈ {001,011,101,111}: +2 (read-modify-write).
- Page cross: when cc=01 and bbb ∈ {100,110,111}, page_cross=1 in any cycle with 0<t_state<len-1 and rdy=1 sets len<=len+1. This applies at most once per instruction. It is ignored for other opcodes, in t_state 0, and in the last cycle.
- Advance: with rdy=1 and last_cycle=0 → t_state+1.
- Boundary: with rdy=1 and last_cycle=1 → t_state<=0, and the next sequence is selected by priority:
  1. nmi_pending → mode=10, len=INT_CYCLES, nmi_pending cleared, nmi_ack=1 in that first cycle.
  2. irq && !i_flag → mode=11, len=INT_CYCLES.
  3. Otherwise → mode=00 (sync).
- Interrupt sequences: opcode=00 throughout; an interrupt is never taken mid-instruction.
- NMI edge: nmi_pending is set on nmi=1 with the previous sample 0. A new edge during the NMI sequence is held pending. Simultaneous set and clear → set wins.
- t_state never exceeds 2^T_W-1; lengths above 2^T_W are illegal parameter values.

Test Plan:
- res high 3 cycles then low → mode=01 for 7 cycles, t_state 0..6, then sync=1, mode=00, t_state=0.
- Sync with instruction=A9 (LDA #) → len 2: t_state 0,1; last_cycle at t=1; sync on the next cycle. AD → 4 cycles. 06 (ASL zp) → 5 cycles. EA → 2 cycles.
- BD (LDA abs,X), page_cross=1 at t=2 → 5 cycles, last_cycle at t=4. Same with page_cross=0 → 4 cycles. Page_cross on 06 → still 5 cycles.
- AD, rdy=0 for 3 cycles at t=2 → t_state stays 2, opcode stays AD; instruction completes 3 cycles late.
- nmi 0→1 at t=1 of AD, irq=1 and i_flag=0 at the same time → AD completes, then mode=10 with nmi_ack pulse, 7 cycles. After that, irq is taken: mode=11, 7 cycles.
- irq=1 with i_flag=1 → no interrupt sequence; consecutive syncs continue. Clear i_flag → IRQ taken at the next instruction boundary.
